// File: rtl/rrv64_core_vec_param_pkg.sv
// Vector-core parameters shared by the writeback arbiter and its picker.
package rrv64_core_vec_param_pkg;

  localparam int VREG_ADDR_WIDTH    = 5;
  localparam int VFULEN             = 64;
  localparam int VRF_WB_NUM_REQ     = 4;
  localparam int VRF_WB_STALL_LIMIT = 64;

  typedef struct packed {
    logic [VREG_ADDR_WIDTH-1:0] addr;
    logic [VFULEN-1:0]          mask;
    logic [VFULEN-1:0]          data;
  } vrf_wb_req_t;

endpackage

// File: rtl/vrf_wb_rr_pick.sv
// Dual-grant round-robin picker: grant A is the first eligible requester from ptr,
// grant B the next eligible one whose address differs from grant A.
module vrf_wb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]        eligible,
  input  logic [PTR_W-1:0]          ptr,
  input  logic [1:0]                capacity,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  output logic [NUM_REQ-1:0]        grant_a,
  output logic [NUM_REQ-1:0]        grant_b,
  output logic                      vld_a,
  output logic                      vld_b
);

  logic [ADDR_W-1:0] addr_a;

  always_comb begin
    grant_a = '0;
    grant_b = '0;
    vld_a   = 1'b0;
    vld_b   = 1'b0;
    addr_a  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (eligible[j] && capacity != 2'd0) begin
        if (!vld_a) begin
          vld_a      = 1'b1;
          grant_a[j] = 1'b1;
          addr_a     = addr[j*ADDR_W +: ADDR_W];
        end else if (!vld_b && capacity == 2'd2 &&
                     addr[j*ADDR_W +: ADDR_W] != addr_a) begin
          // same-address followers wait a cycle so WAW order holds
          vld_b      = 1'b1;
          grant_b[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vrf_wb_arbiter.sv
// Shares the two vector-regfile write ports among NUM_REQ writeback requesters,
// holding each winner in an output slot until the regfile takes it.
module vrf_wb_arbiter
  import rrv64_core_vec_param_pkg::*;
#(
  parameter int NUM_REQ     = VRF_WB_NUM_REQ,
  parameter int ADDR_W      = VREG_ADDR_WIDTH,
  parameter int DATA_W      = VFULEN,
  parameter int STALL_LIMIT = VRF_WB_STALL_LIMIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_vld,
  output logic [NUM_REQ-1:0]        req_rdy,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_mask,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      wr0_vld,
  input  logic                      wr0_conflict,
  output logic [ADDR_W-1:0]         waddr0,
  output logic [DATA_W-1:0]         wmask0,
  output logic [DATA_W-1:0]         wdata0,
  output logic                      wr1_vld,
  input  logic                      wr1_conflict,
  output logic [ADDR_W-1:0]         waddr1,
  output logic [DATA_W-1:0]         wmask1,
  output logic [DATA_W-1:0]         wdata1,
  output logic                      idle,
  output logic                      stall_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(STALL_LIMIT + 1);

  logic [1:0]        slot_vld_reg;
  logic [ADDR_W-1:0] slot_addr_reg [2];
  logic [DATA_W-1:0] slot_mask_reg [2];
  logic [DATA_W-1:0] slot_data_reg [2];
  logic [CNT_W-1:0]  stall_cnt_reg [2];
  logic              stall_err_reg;
  logic [PTR_W-1:0]  ptr_reg;
  logic [PTR_W-1:0]  ptr_next;

  logic [1:0]         conflict;
  logic [1:0]         slot_free;
  logic [1:0]         slot_blk;
  logic [1:0]         capacity;
  logic [1:0]         load_a;
  logic [1:0]         load_b;
  logic [1:0]         stall_hit;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant_a;
  logic [NUM_REQ-1:0] grant_b;
  logic               vld_a;
  logic               vld_b;
  logic [ADDR_W-1:0]  a_addr, b_addr;
  logic [DATA_W-1:0]  a_mask, b_mask, a_data, b_data;
  int                 last_idx;

  assign conflict  = {wr1_conflict, wr0_conflict};
  assign slot_free = ~slot_vld_reg | ~conflict;
  assign slot_blk  = slot_vld_reg & conflict;
  assign capacity  = {1'b0, slot_free[0]} + {1'b0, slot_free[1]};

  // only a slot that is retrying blocks a matching address; a writing slot does not
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
      assign eligible[gi] = req_vld[gi]
        & ~(slot_blk[0] & (req_addr[gi*ADDR_W +: ADDR_W] == slot_addr_reg[0]))
        & ~(slot_blk[1] & (req_addr[gi*ADDR_W +: ADDR_W] == slot_addr_reg[1]));
    end
  endgenerate

  vrf_wb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .PTR_W   (PTR_W)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr_reg),
    .capacity (capacity),
    .addr     (req_addr),
    .grant_a  (grant_a),
    .grant_b  (grant_b),
    .vld_a    (vld_a),
    .vld_b    (vld_b)
  );

  assign req_rdy = grant_a | grant_b;

  always_comb begin
    a_addr   = '0;
    a_mask   = '0;
    a_data   = '0;
    b_addr   = '0;
    b_mask   = '0;
    b_data   = '0;
    last_idx = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_a[i]) begin
        a_addr = req_addr[i*ADDR_W +: ADDR_W];
        a_mask = req_mask[i*DATA_W +: DATA_W];
        a_data = req_data[i*DATA_W +: DATA_W];
        if (!vld_b) last_idx = i;
      end
      if (grant_b[i]) begin
        b_addr   = req_addr[i*ADDR_W +: ADDR_W];
        b_mask   = req_mask[i*DATA_W +: DATA_W];
        b_data   = req_data[i*DATA_W +: DATA_W];
        last_idx = i;
      end
    end
    ptr_next = ptr_reg;
    if (vld_a) ptr_next = (last_idx == NUM_REQ - 1) ? '0 : PTR_W'(last_idx + 1);
  end

  // grant A takes the lowest freeing slot; B only exists when both slots free
  assign load_a = {vld_a & ~slot_free[0], vld_a & slot_free[0]};
  assign load_b = {vld_b, 1'b0};

  always_comb begin
    stall_hit = 2'b00;
    for (int k = 0; k < 2; k++)
      stall_hit[k] = ~slot_free[k] & (stall_cnt_reg[k] >= CNT_W'(STALL_LIMIT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_vld_reg  <= 2'b00;
      stall_err_reg <= 1'b0;
      ptr_reg       <= '0;
      for (int k = 0; k < 2; k++) begin
        slot_addr_reg[k] <= '0;
        slot_mask_reg[k] <= '0;
        slot_data_reg[k] <= '0;
        stall_cnt_reg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (slot_free[k]) begin
          stall_cnt_reg[k] <= '0;
          slot_vld_reg[k]  <= load_a[k] | load_b[k];
          if (load_b[k]) begin
            slot_addr_reg[k] <= b_addr;
            slot_mask_reg[k] <= b_mask;
            slot_data_reg[k] <= b_data;
          end else if (load_a[k]) begin
            slot_addr_reg[k] <= a_addr;
            slot_mask_reg[k] <= a_mask;
            slot_data_reg[k] <= a_data;
          end
        end else if (stall_cnt_reg[k] != CNT_W'(STALL_LIMIT)) begin
          stall_cnt_reg[k] <= stall_cnt_reg[k] + 1'b1;
        end
      end
      if (|stall_hit) stall_err_reg <= 1'b1;
      ptr_reg <= ptr_next;
    end
  end

  assign wr0_vld   = slot_vld_reg[0];
  assign waddr0    = slot_addr_reg[0];
  assign wmask0    = slot_mask_reg[0];
  assign wdata0    = slot_data_reg[0];
  assign wr1_vld   = slot_vld_reg[1];
  assign waddr1    = slot_addr_reg[1];
  assign wmask1    = slot_mask_reg[1];
  assign wdata1    = slot_data_reg[1];
  assign idle      = ~slot_vld_reg[0] & ~slot_vld_reg[1] & ~|req_vld;
  assign stall_err = stall_err_reg;

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Directed bench for vrf_wb_arbiter: grants, hazards, WAW order, stall flag, async reset.
module tb_vrf_wb_arbiter;

  localparam int NR = 4;
  localparam int AW = 5;
  localparam int DW = 64;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_vld;
  logic [NR-1:0]    req_rdy;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_mask;
  logic [NR*DW-1:0] req_data;
  logic             wr0_vld, wr0_conflict;
  logic [AW-1:0]    waddr0;
  logic [DW-1:0]    wmask0, wdata0;
  logic             wr1_vld, wr1_conflict;
  logic [AW-1:0]    waddr1;
  logic [DW-1:0]    wmask1, wdata1;
  logic             idle, stall_err;

  int total = 0;
  int bad   = 0;

  vrf_wb_arbiter #(
    .NUM_REQ     (NR),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .STALL_LIMIT (64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_vld      (req_vld),
    .req_rdy      (req_rdy),
    .req_addr     (req_addr),
    .req_mask     (req_mask),
    .req_data     (req_data),
    .wr0_vld      (wr0_vld),
    .wr0_conflict (wr0_conflict),
    .waddr0       (waddr0),
    .wmask0       (wmask0),
    .wdata0       (wdata0),
    .wr1_vld      (wr1_vld),
    .wr1_conflict (wr1_conflict),
    .waddr1       (waddr1),
    .wmask1       (wmask1),
    .wdata1       (wdata1),
    .idle         (idle),
    .stall_err    (stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("pass %s val=%0h", tag, got);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a,
                         input logic [DW-1:0] m, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_mask[i*DW +: DW] = m;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req_vld = '0;
    req_addr = '0;
    req_mask = '0;
    req_data = '0;
    wr0_conflict = 1'b0;
    wr1_conflict = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr0_vld", wr0_vld, 1'b0);
    chk("rst_wr1_vld", wr1_vld, 1'b0);
    chk("rst_stall_err", stall_err, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_waddr0", waddr0, 0);
    chk("rst_wdata1", wdata1, 0);
    rst = 1'b0;

    // single request: same-cycle rdy, write one cycle later, then idle
    tick();
    set_req(0, 5'd5, 64'h0000_FFFF_0000_FFFF, 64'hDEAD_BEEF_0000_0001);
    req_vld = 4'b0001;
    @(negedge clk);
    chk("t1_rdy", req_rdy, 4'b0001);
    chk("t1_busy", idle, 1'b0);
    tick();
    req_vld = 4'b0000;
    @(negedge clk);
    chk("t1_wr0_vld", wr0_vld, 1'b1);
    chk("t1_waddr0", waddr0, 5);
    chk("t1_wdata0", wdata0, 64'hDEAD_BEEF_0000_0001);
    chk("t1_wmask0", wmask0, 64'h0000_FFFF_0000_FFFF);
    chk("t1_wr1_vld", wr1_vld, 1'b0);
    tick();
    @(negedge clk);
    chk("t1_idle", idle, 1'b1);
    chk("t1_wr0_done", wr0_vld, 1'b0);

    // four requesters: {0,1} then {2,3}, then pointer back at 0
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, AW'(i + 1), 64'hFF, 64'h100 + 64'(i));
    req_vld = 4'b1111;
    @(negedge clk);
    chk("t2_rdy_01", req_rdy, 4'b0011);
    tick();
    req_vld = 4'b1100;
    @(negedge clk);
    chk("t2_rdy_23", req_rdy, 4'b1100);
    chk("t2_wr0_vld", wr0_vld, 1'b1);
    chk("t2_wr1_vld", wr1_vld, 1'b1);
    chk("t2_waddr0_a", waddr0, 1);
    chk("t2_waddr1_a", waddr1, 2);
    chk("t2_wdata1_a", wdata1, 64'h101);
    tick();
    for (int i = 0; i < NR; i++) set_req(i, AW'(i + 6), 64'hF0, 64'h200 + 64'(i));
    req_vld = 4'b1111;
    @(negedge clk);
    chk("t2_waddr0_b", waddr0, 3);
    chk("t2_waddr1_b", waddr1, 4);
    chk("t2_wdata0_b", wdata0, 64'h102);
    chk("t2_wrap_rdy", req_rdy, 4'b0011);
    tick();
    req_vld = 4'b0000;
    @(negedge clk);
    chk("t2_waddr0_c", waddr0, 6);
    chk("t2_waddr1_c", waddr1, 7);

    // retrying slot blocks a same-address request; order preserved
    do_reset();
    set_req(0, 5'd7, 64'h1, 64'hAAAA);
    req_vld = 4'b0001;
    @(negedge clk);
    chk("t3_rdy0", req_rdy, 4'b0001);
    tick();
    set_req(1, 5'd7, 64'h2, 64'hBBBB);
    req_vld = 4'b0010;
    wr0_conflict = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t3_blocked", req_rdy, 4'b0000);
      chk("t3_hold_data", wdata0, 64'hAAAA);
      @(posedge clk);
      #1;
    end
    wr0_conflict = 1'b0;
    @(negedge clk);
    chk("t3_grant1", req_rdy, 4'b0010);
    chk("t3_first_wr", wdata0, 64'hAAAA);
    tick();
    req_vld = 4'b0000;
    @(negedge clk);
    chk("t3_second_vld", wr0_vld, 1'b1);
    chk("t3_second_addr", waddr0, 7);
    chk("t3_second_data", wdata0, 64'hBBBB);

    // same address in one cycle: only the first is granted
    do_reset();
    set_req(0, 5'd9, 64'h3, 64'hC0C0);
    set_req(2, 5'd9, 64'h4, 64'hD0D0);
    req_vld = 4'b0101;
    @(negedge clk);
    chk("t4_rdy_first", req_rdy, 4'b0001);
    tick();
    req_vld = 4'b0100;
    @(negedge clk);
    chk("t4_rdy_second", req_rdy, 4'b0100);
    chk("t4_wdata0_a", wdata0, 64'hC0C0);
    tick();
    req_vld = 4'b0000;
    @(negedge clk);
    chk("t4_waddr0_b", waddr0, 9);
    chk("t4_wdata0_b", wdata0, 64'hD0D0);

    // slot 1 conflicted for 64 cycles sets sticky stall_err
    do_reset();
    set_req(0, 5'd10, 64'h5, 64'hE0E0);
    set_req(1, 5'd11, 64'h6, 64'hF0F0);
    req_vld = 4'b0011;
    @(negedge clk);
    chk("t5_rdy", req_rdy, 4'b0011);
    tick();
    req_vld = 4'b0000;
    wr1_conflict = 1'b1;
    @(negedge clk);
    chk("t5_wr1_vld", wr1_vld, 1'b1);
    chk("t5_waddr1", waddr1, 11);
    repeat (63) @(posedge clk);
    @(negedge clk);
    chk("t5_err_63", stall_err, 1'b0);
    chk("t5_wdata1_held", wdata1, 64'hF0F0);
    @(posedge clk);
    @(negedge clk);
    chk("t5_err_64", stall_err, 1'b1);
    wr1_conflict = 1'b0;
    @(negedge clk);
    chk("t5_wr1_freed", wr1_vld, 1'b0);
    chk("t5_err_sticky", stall_err, 1'b1);
    chk("t5_idle", idle, 1'b1);

    // async reset with both slots occupied; pointer restarts at 0
    @(posedge clk);
    #1;
    set_req(0, 5'd1, 64'h7, 64'h1111);
    set_req(1, 5'd2, 64'h8, 64'h2222);
    req_vld = 4'b0011;
    wr0_conflict = 1'b1;
    wr1_conflict = 1'b1;
    @(negedge clk);
    chk("t6_rdy_fill", req_rdy, 4'b0011);
    tick();
    set_req(2, 5'd5, 64'h9, 64'h3333);
    req_vld = 4'b0100;
    @(negedge clk);
    chk("t6_cap0_rdy", req_rdy, 4'b0000);
    chk("t6_wr0_full", wr0_vld, 1'b1);
    chk("t6_wr1_full", wr1_vld, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_async_wr0", wr0_vld, 1'b0);
    chk("t6_async_wr1", wr1_vld, 1'b0);
    chk("t6_async_err", stall_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wr0_conflict = 1'b0;
    wr1_conflict = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, AW'(i + 1), 64'h1, 64'h400 + 64'(i));
    req_vld = 4'b1111;
    #1;
    chk("t6_ptr0_rdy", req_rdy, 4'b0011);
    tick();
    req_vld = 4'b0000;
    @(negedge clk);
    chk("t6_waddr0", waddr0, 1);
    chk("t6_waddr1", waddr1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
